// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 64;
  localparam int unsigned REG_ZR     = 31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback holding slot. Accepts when empty or when being drained
// this cycle; writes to the zero register are accepted but never stored.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drop,
  input  logic              drain,
  output logic              loaded,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Ready and load strobe; load wins over drain on the same edge.
  always_comb begin
    in_ready = !full_q || drain;
    loaded   = in_valid && in_ready && !drop;
  end

  // Slot storage: refill, drain or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (loaded) begin
      full_q <= 1'b1;
      addr_q <= in_addr;
      data_q <= in_data;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and the
// memory writeback sources, and exports a per-register pending vector.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned ZR_ADDR = REG_ZR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 we3,
  output logic [ADDR_W-1:0]    wa3,
  output logic [DATA_W-1:0]    wd3,
  output logic [2**ADDR_W-1:0] pending
);

  logic              alu_full, mem_full;
  logic              alu_load, mem_load;
  logic              alu_drop, mem_drop;
  logic [ADDR_W-1:0] alu_a, mem_a;
  logic [DATA_W-1:0] alu_d, mem_d;
  logic              gnt_alu, gnt_mem;

  // tie_q: both current entries were loaded on the same edge.
  // older_q: which slot was loaded first when they were not.
  logic              tie_q;
  src_e              older_q;
  src_e              last_grant_q;
  logic [ADDR_W-1:0] last_wa_q;
  logic [DATA_W-1:0] last_wd_q;

  assign alu_drop = (alu_addr == ADDR_W'(ZR_ADDR));
  assign mem_drop = (mem_addr == ADDR_W'(ZR_ADDR));

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (alu_valid),
    .in_ready (alu_ready),
    .in_addr  (alu_addr),
    .in_data  (alu_data),
    .drop     (alu_drop),
    .drain    (gnt_alu),
    .loaded   (alu_load),
    .full     (alu_full),
    .addr     (alu_a),
    .data     (alu_d)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (mem_valid),
    .in_ready (mem_ready),
    .in_addr  (mem_addr),
    .in_data  (mem_data),
    .drop     (mem_drop),
    .drain    (gnt_mem),
    .loaded   (mem_load),
    .full     (mem_full),
    .addr     (mem_a),
    .data     (mem_d)
  );

  // Grant from slot state only: sole entry, then age, then same-address
  // ALU-first ordering, then round-robin.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    unique case ({alu_full, mem_full})
      2'b10: gnt_alu = 1'b1;
      2'b01: gnt_mem = 1'b1;
      2'b11: begin
        if (!tie_q) begin
          gnt_alu = (older_q == SRC_ALU);
        end else if (alu_a == mem_a) begin
          gnt_alu = 1'b1;
        end else begin
          gnt_alu = (last_grant_q == SRC_MEM);
        end
        gnt_mem = !gnt_alu;
      end
      default: ;
    endcase
  end

  // Write port driven from slot flops; address/data hold when idle.
  always_comb begin
    we3 = gnt_alu || gnt_mem;
    wa3 = last_wa_q;
    wd3 = last_wd_q;
    if (gnt_alu) begin
      wa3 = alu_a;
      wd3 = alu_d;
    end else if (gnt_mem) begin
      wa3 = mem_a;
      wd3 = mem_d;
    end
  end

  // Pending decode of uncommitted destinations.
  always_comb begin
    pending = '0;
    if (alu_full) pending[alu_a] = 1'b1;
    if (mem_full) pending[mem_a] = 1'b1;
  end

  // Age tracking: a freshly loaded entry is always the youngest, and the
  // flag is left alone when neither slot reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tie_q   <= 1'b0;
      older_q <= SRC_ALU;
    end else if (alu_load && mem_load) begin
      tie_q   <= 1'b1;
    end else if (alu_load) begin
      tie_q   <= 1'b0;
      older_q <= SRC_MEM;
    end else if (mem_load) begin
      tie_q   <= 1'b0;
      older_q <= SRC_ALU;
    end
  end

  // Round-robin history and held write-port values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= SRC_MEM;
      last_wa_q    <= '0;
      last_wd_q    <= '0;
    end else if (we3) begin
      last_grant_q <= gnt_alu ? SRC_ALU : SRC_MEM;
      last_wa_q    <= wa3;
      last_wd_q    <= wd3;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between two writeback sources: the ALU result path and the memory/load return path.
- Each source gets a one-entry holding slot with a valid/ready handshake.
- An age-then-round-robin arbiter commits one slot per cycle.
- A per-register pending vector is exported for hazard/stall logic. Sits between execute/memory stages and the register file.

Parameters:
DATA_W, 64, width of write data
ADDR_W, 5, register address width
ZR_ADDR, 31, zero-register index; writes to it are discarded

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU source presents a write
alu_ready  output  1  ALU slot can accept this cycle
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU write data
mem_valid  input  1  memory source presents a write
mem_ready  output  1  memory slot can accept this cycle
mem_addr  input  ADDR_W  memory destination register
mem_data  input  DATA_W  memory write data
we3  output  1  register file write enable
wa3  output  ADDR_W  register file write address
wd3  output  DATA_W  register file write data
pending  output  2**ADDR_W  bit r = a slot holds an uncommitted write to register r

Behaviour:
- Reset (async, any time, including mid-operation): both slots empty, age flag cleared, last_grant = MEM (so ALU wins the next tie); we3=0, wa3=0, wd3=0, pending=0, alu_ready=mem_ready=1 while reset is deasserted and slots are empty. In-flight slot contents are lost.
- Accept: x_valid && x_ready at a posedge. The slot loads {addr,data} at that edge.
- x_ready = slot empty OR slot is granted this cycle. A full slot drains and refills on the same edge, giving sustained 1 write/cycle per source when uncontested.
- ZR_ADDR writes: accepted (ready semantics unchanged) but the slot is not loaded. They never reach we3 and never set pending.
- Grant (combinational from slot state only, never from inputs):
  - Only one slot full -> grant it.
  - Both full, loaded on different edges -> the older slot wins. A 1-bit age flag records which slot was loaded first.
  - Both full, loaded on the same edge, same address -> ALU first, so the MEM value is the final register content.
  - Both full, loaded on the same edge, different addresses -> round-robin against last_grant; last_grant updates on every grant.
- Outputs:
  - we3 = any slot granted; wa3/wd3 = granted slot contents. Driven from flops only, so the register file sees stable values for the whole cycle and writes on the next posedge.
  - With no grant: we3=0 and wa3/wd3 hold their last values.
- Latency: accept at edge N -> we3 high during cycle N..N+1 -> register written at edge N+1. A contested slot waits at most 1 extra cycle.
- pending[r] = (alu slot full && alu addr==r) || (mem slot full && mem addr==r). Purely a function of slot state; clears on the commit edge unless the same edge reloads that address.
- Simultaneous grant of a slot and new accept on that slot: the commit uses old contents, the slot holds new contents, and the age flag treats the new entry as youngest.
- No backpressure from the register file: every grant commits in one cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W, REG_DATA_W, REG_ZR constants
  - wb_req_t struct {addr, data}
  - src_e enum {SRC_ALU, SRC_MEM}
- One sub-module, wb_slot: a one-entry holding buffer with valid/ready, a load/drain interface and a ZR-drop input. Instantiated twice. Arbitration, age flag and pending decode stay in the top.

Test Plan:
- Reset mid-traffic: both slots full (X3, X4), assert reset asynchronously -> we3=0 and pending=0 immediately; alu_ready=mem_ready=1 after release; no write to X3/X4.
- Single ALU write X5=0x1234 accepted at edge N -> we3=1, wa3=5, wd3=0x1234 during cycle N+1; pending[5]=1 for exactly that cycle.
- Both sources valid, same edge, X7: ALU=0xA, MEM=0xB -> commits in order 0xA then 0xB on consecutive cycles; pending[7] high for 2 cycles; final X7=0xB.
- Both sources streaming to different registers every cycle -> grants alternate ALU/MEM; each source's ready toggles (accepts every other cycle); no write lost or duplicated over 20 writes.
- Write to X31 from MEM with data 0xFFFF -> accepted, we3 stays 0, pending stays 0.
- Age ordering: MEM loads X9 at edge N while the ALU slot is blocked; ALU loads X9 at edge N+1 -> MEM commits before ALU; final X9 = ALU data.
